// File: rtl/instr_fetch_unit.sv
// Byte-serial Y86-64 instruction fetcher.
// Reads one instruction, one byte per req/ack handshake, and splits it into
// icode/ifun/rA/rB/valC. It also computes valP and raises IMemReady, which
// releases the microsequencer from its fetch-wait state.
module instr_fetch_unit #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              IMemReady,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_invalid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_idx;
  logic [3:0]        r_len;
  logic              r_req;
  logic              r_ready;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [3:0]        r_ra;
  logic [3:0]        r_rb;
  logic [63:0]       r_valc;
  logic [ADDR_W-1:0] r_valp;
  logic              r_invalid;

  logic              w_start;
  logic              w_take;
  logic              w_first;
  logic [3:0]        w_len;
  logic              w_last;
  logic [2:0]        w_k;

  // Instruction length in bytes, decoded from icode.
  function automatic logic [3:0] f_len(input logic [3:0] code);
    logic [3:0] len;
    case (code)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;  // halt, nop, ret and invalid codes
    endcase
    return len;
  endfunction

  // Handshake qualification, length in force for this byte, and where a constant byte lands.
  always_comb begin
    w_start = fetch_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_take  = (r_state == S_FETCH) && r_req && imem_ack;
    w_first = (r_idx == 4'd0);
    if (w_first) begin
      w_len = f_len(imem_rdata[7:4]);
    end else begin
      w_len = r_len;
    end
    w_last = (r_idx == (w_len - 4'd1));
    // jXX/call constants start at byte 1; irmov/rmmov/mrmov constants at byte 2.
    if (r_len == 4'd9) begin
      w_k = 3'(r_idx - 4'd1);
    end else begin
      w_k = 3'(r_idx - 4'd2);
    end
  end

  // Fetch FSM: start latching, per-byte field capture, and completion with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_addr    <= '0;
      r_idx     <= 4'd0;
      r_len     <= 4'd0;
      r_req     <= 1'b0;
      r_ready   <= 1'b0;
      r_icode   <= 4'h0;
      r_ifun    <= 4'h0;
      r_ra      <= 4'hF;
      r_rb      <= 4'hF;
      r_valc    <= 64'd0;
      r_valp    <= '0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state   <= S_FETCH;
            r_pc      <= pc;
            r_addr    <= pc;
            r_idx     <= 4'd0;
            r_req     <= 1'b1;
            r_ready   <= 1'b0;
            r_ra      <= 4'hF;
            r_rb      <= 4'hF;
            r_valc    <= 64'd0;
            r_invalid <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_FETCH: begin
          if (w_take) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_idx  <= r_idx + 4'd1;
            if (w_first) begin
              r_icode   <= imem_rdata[7:4];
              r_ifun    <= imem_rdata[3:0];
              r_len     <= w_len;
              r_invalid <= (imem_rdata[7:4] >= 4'hC);
            end else begin
              case (r_len)
                4'd2: begin
                  r_ra <= imem_rdata[7:4];
                  r_rb <= imem_rdata[3:0];
                end
                4'd9: begin
                  r_valc[{w_k, 3'b000} +: 8] <= imem_rdata;
                end
                4'd10: begin
                  if (r_idx == 4'd1) begin
                    r_ra <= imem_rdata[7:4];
                    r_rb <= imem_rdata[3:0];
                  end else begin
                    r_valc[{w_k, 3'b000} +: 8] <= imem_rdata;
                  end
                end
                default: begin
                  r_valc <= r_valc;
                end
              endcase
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_req   <= 1'b0;
              r_ready <= 1'b1;
              r_valp  <= r_pc + {{(ADDR_W-4){1'b0}}, w_len};
            end else begin
              r_state <= S_FETCH;
            end
          end else begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_addr;
  assign IMemReady     = r_ready;
  assign icode         = r_icode;
  assign ifun          = r_ifun;
  assign rA            = r_ra;
  assign rB            = r_rb;
  assign valC          = r_valc;
  assign valP          = r_valp;
  assign instr_invalid = r_invalid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a byte-memory responder.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic [63:0] pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        IMemReady;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_invalid;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  mem [0:15];
  logic [63:0] mem_base = 64'd0;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  logic        force_ack = 1'b0;
  int          req_count = 0;
  logic [63:0] addr_log [$];

  instr_fetch_unit #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IMemReady(IMemReady), .icode(icode),
    .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_invalid(instr_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: ack after ack_wait idle cycles per byte; logs every request cycle.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt < ack_wait) begin
        imem_ack = 1'b0;
        wait_cnt = wait_cnt + 1;
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = mem[4'(imem_addr - mem_base)];
        wait_cnt   = 0;
      end
      req_count = req_count + 1;
      addr_log.push_back(imem_addr);
    end else begin
      imem_ack = force_ack;
      wait_cnt = 0;
    end
  end

  task automatic load_mem(input logic [63:0] base, input logic [7:0] b [0:15]);
    mem_base = base;
    for (int i = 0; i < 16; i++) mem[i] = b[i];
  endtask

  task automatic do_fetch(input logic [63:0] a_pc, input int wait_n,
                          output int edges, output logic rdy1);
    ack_wait = wait_n;
    @(negedge clk);
    pc = a_pc;
    fetch_start = 1'b1;
    req_count = 0;
    addr_log.delete();
    @(negedge clk);
    fetch_start = 1'b0;
    edges = 1;
    rdy1 = IMemReady;
    while (!IMemReady && edges < 300) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({imem_req, IMemReady, instr_invalid} !== 3'b000 || imem_addr !== 64'd0)
      $display("FAIL reset_ctrl got req=%b rdy=%b inv=%b addr=%h exp 0", imem_req, IMemReady, instr_invalid, imem_addr);
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h00FF || valC !== 64'd0 || valP !== 64'd0)
      $display("FAIL reset_fields got %h%h%h%h valC=%h valP=%h exp 00FF/0/0", icode, ifun, rA, rB, valC, valP);
    else pass_cnt++;
  endtask

  task automatic test_one_byte();
    logic [7:0] b [0:15];
    int edges; logic rdy1;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'h10;
    load_mem(64'h100, b);
    do_fetch(64'h100, 0, edges, rdy1);
    total_cnt++;
    if (req_count !== 1 || addr_log[0] !== 64'h100)
      $display("FAIL t1_req got cycles=%0d addr=%h exp 1 @100", req_count, addr_log[0]);
    else pass_cnt++;
    total_cnt++;
    if (edges !== 2) $display("FAIL t1_latency got %0d exp 2", edges);
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h10FF || valP !== 64'h101 || valC !== 64'd0)
      $display("FAIL t1_fields got %h%h%h%h valP=%h valC=%h exp 10FF 101 0", icode, ifun, rA, rB, valP, valC);
    else pass_cnt++;
  endtask

  task automatic test_irmovq();
    logic [7:0] b [0:15];
    int edges; logic rdy1;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'h30; b[1] = 8'hF3;
    for (int i = 0; i < 8; i++) b[2+i] = 8'(8 - i);
    load_mem(64'h2000, b);
    do_fetch(64'h2000, 0, edges, rdy1);
    total_cnt++;
    if (rdy1 !== 1'b0) $display("FAIL t2_ready_drop got %b exp 0", rdy1);
    else pass_cnt++;
    total_cnt++;
    if (req_count !== 10 || edges !== 11)
      $display("FAIL t2_timing got req=%0d edges=%0d exp 10 11", req_count, edges);
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h30F3 || valC !== 64'h0102030405060708 || valP !== 64'h200A)
      $display("FAIL t2_fields got %h%h%h%h valC=%h valP=%h exp 30F3 0102030405060708 200A", icode, ifun, rA, rB, valC, valP);
    else pass_cnt++;
  endtask

  task automatic test_jxx_waits();
    logic [7:0] b [0:15];
    int edges; logic rdy1; logic ok;
    for (int i = 0; i < 16; i++) b[i] = 8'h11;
    b[0] = 8'h73;
    load_mem(64'h3000, b);
    do_fetch(64'h3000, 2, edges, rdy1);
    ok = (addr_log.size() == 27);
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== 64'h3000 + 64'(i / 3)) ok = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL t3_addr_hold got %0d req cycles with bad address sequence exp 27 held", addr_log.size());
    else pass_cnt++;
    total_cnt++;
    if (edges !== 28) $display("FAIL t3_latency got %0d exp 28", edges);
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h73FF || valC !== 64'h1111111111111111 || valP !== 64'h3009)
      $display("FAIL t3_fields got %h%h%h%h valC=%h valP=%h exp 73FF 1111111111111111 3009", icode, ifun, rA, rB, valC, valP);
    else pass_cnt++;
    ack_wait = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] b [0:15];
    int edges; logic rdy1;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'h60; b[1] = 8'h12;
    load_mem(64'hFFFF_FFFF_FFFF_FFFE, b);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFE, 0, edges, rdy1);
    total_cnt++;
    if (req_count !== 2 || addr_log[0] !== 64'hFFFF_FFFF_FFFF_FFFE || addr_log[1] !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL t4_addr got n=%0d %h %h exp 2 FF..FE FF..FF", req_count, addr_log[0], addr_log[1]);
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h6012 || valP !== 64'd0 || instr_invalid !== 1'b0)
      $display("FAIL t4_fields got %h%h%h%h valP=%h inv=%b exp 6012 0 0", icode, ifun, rA, rB, valP, instr_invalid);
    else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [7:0] b [0:15];
    int edges; logic rdy1;
    for (int i = 0; i < 16; i++) b[i] = 8'h55;
    b[0] = 8'hE0;
    load_mem(64'h4000, b);
    do_fetch(64'h4000, 0, edges, rdy1);
    total_cnt++;
    if (instr_invalid !== 1'b1 || IMemReady !== 1'b1 || req_count !== 1 || icode !== 4'hE)
      $display("FAIL t5_invalid got inv=%b rdy=%b req=%0d icode=%h exp 1 1 1 E", instr_invalid, IMemReady, req_count, icode);
    else pass_cnt++;
    total_cnt++;
    if (valP !== 64'h4001 || valC !== 64'd0 || rA !== 4'hF)
      $display("FAIL t5_valp got valP=%h valC=%h rA=%h exp 4001 0 F", valP, valC, rA);
    else pass_cnt++;
  endtask

  task automatic test_start_mid_fetch();
    logic [7:0] b [0:15];
    int n; logic ok;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'h20; b[1] = 8'h45;
    load_mem(64'h500, b);
    ack_wait = 2;
    @(negedge clk);
    pc = 64'h500; fetch_start = 1'b1;
    req_count = 0; addr_log.delete();
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    pc = 64'h900; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (!IMemReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (addr_log.size() == 6);
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== 64'h500 + 64'(i / 3)) ok = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL mid_start_addr got %0d req cycles exp 6 at 500/501", addr_log.size());
    else pass_cnt++;
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h2045 || valP !== 64'h502 || IMemReady !== 1'b1)
      $display("FAIL mid_start_fields got %h%h%h%h valP=%h rdy=%b exp 2045 502 1", icode, ifun, rA, rB, valP, IMemReady);
    else pass_cnt++;
    ack_wait = 0;
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] b [0:15];
    int edges; logic rdy1; int n;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    b[0] = 8'h30; b[1] = 8'hF3;
    for (int i = 2; i < 10; i++) b[i] = 8'hAA;
    load_mem(64'h600, b);
    ack_wait = 0;
    @(negedge clk);
    pc = 64'h600; fetch_start = 1'b1;
    req_count = 0; addr_log.delete();
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (req_count < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if (imem_req !== 1'b0 || IMemReady !== 1'b0 || rA !== 4'hF || valC !== 64'd0 || icode !== 4'h0)
      $display("FAIL t6_reset got req=%b rdy=%b rA=%h valC=%h icode=%h exp 0 0 F 0 0", imem_req, IMemReady, rA, valC, icode);
    else pass_cnt++;
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (imem_req !== 1'b0 || IMemReady !== 1'b0 || imem_addr !== 64'd0)
      $display("FAIL t6_late_ack got req=%b rdy=%b addr=%h exp 0 0 0", imem_req, IMemReady, imem_addr);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) b[i] = 8'h77;
    b[0] = 8'h90;
    load_mem(64'h700, b);
    do_fetch(64'h700, 0, edges, rdy1);
    total_cnt++;
    if ({icode, ifun, rA, rB} !== 16'h90FF || valC !== 64'd0 || valP !== 64'h701 || IMemReady !== 1'b1 || edges !== 2)
      $display("FAIL t6_ret got %h%h%h%h valC=%h valP=%h rdy=%b edges=%0d exp 90FF 0 701 1 2", icode, ifun, rA, rB, valC, valP, IMemReady, edges);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    fetch_start = 1'b0;
    pc = 64'd0;
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    test_reset();
    test_one_byte();
    test_irmovq();
    test_jxx_waits();
    test_wrap();
    test_invalid();
    test_start_mid_fetch();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
